// File: rtl/instruction_fetch_stage.sv
// IF stage of the five-stage MIPS pipeline: owns the PC and the IF/ID register,
// and applies redirects, hazard stalls and out-of-range fetch protection.
module instruction_fetch_stage #(
    parameter int          INSTR_MEM_SIZE = 64,
    parameter logic [31:0] PC_RESET       = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        out_of_range,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_WORDS = 32'(INSTR_MEM_SIZE);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        oor;

    // Range check depends only on the PC register, never on this cycle's inputs.
    assign oor      = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= MEM_WORDS);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (branch_taken) begin
            pc_d       = branch_target;
            instr_d    = 32'd0;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (oor) begin
            // halted: memory data may be X here, so only a bubble is loaded
            instr_d    = 32'd0;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else begin
            pc_d       = pc_plus4;
            instr_d    = imem_data;
            pc_plus4_d = pc_plus4;
            valid_d    = 1'b1;
            count_d    = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign pc                = pc_q;
    assign imem_addr         = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pc_plus4_q;
    assign if_id_valid       = valid_q;
    assign out_of_range      = oor;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a behavioural 64-word instruction memory.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        out_of_range;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];
    int tests = 0;
    int fails = 0;

    instruction_fetch_stage #(.INSTR_MEM_SIZE(64), .PC_RESET(32'h0)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .out_of_range(out_of_range),
        .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    assign imem_data = (imem_addr[31:8] == 24'd0) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_seq();
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + i;
    endtask

    task automatic restart();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) mem[i] = 32'hFFFF_FFFF;
        reset = 1'b1;
        step(); step();
        tests++; if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, 32'd0); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        tests++; if (fetch_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        tests++; if (if_id_instruction !== 32'd0) begin fails++; $display("FAIL reset_instr got %h exp 0", if_id_instruction); end
        reset = 1'b0;
        step();
        tests++; if (if_id_instruction !== 32'hFFFF_FFFF) begin fails++; $display("FAIL first_instr got %h exp ffffffff", if_id_instruction); end
        tests++; if (if_id_pc_plus4 !== 32'd4) begin fails++; $display("FAIL first_pc4 got %h exp 4", if_id_pc_plus4); end
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", if_id_valid); end
        tests++; if (pc !== 32'd4) begin fails++; $display("FAIL first_pc got %h exp 4", pc); end
    endtask

    task automatic test_sequential();
        load_seq();
        restart();
        for (int i = 0; i < 5; i++) step();
        tests++; if (pc !== 32'd20) begin fails++; $display("FAIL seq_pc got %0d exp 20", pc); end
        tests++; if (if_id_instruction !== 32'h2000_0004) begin fails++; $display("FAIL seq_instr got %h exp 20000004", if_id_instruction); end
        tests++; if (if_id_pc_plus4 !== 32'd20) begin fails++; $display("FAIL seq_pc4 got %0d exp 20", if_id_pc_plus4); end
        tests++; if (fetch_count !== 32'd5) begin fails++; $display("FAIL seq_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_stall();
        restart();
        step(); step();
        tests++; if (pc !== 32'd8) begin fails++; $display("FAIL stall_setup_pc got %0d exp 8", pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (pc !== 32'd8) begin fails++; $display("FAIL stall_pc got %0d exp 8", pc); end
            tests++; if (if_id_instruction !== 32'h2000_0001 || if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'd8)
                begin fails++; $display("FAIL stall_ifid got %h/%0d/%b exp 20000001/8/1", if_id_instruction, if_id_pc_plus4, if_id_valid); end
            tests++; if (fetch_count !== 32'd2) begin fails++; $display("FAIL stall_count got %0d exp 2", fetch_count); end
        end
        stall = 1'b0;
        step();
        tests++; if (if_id_instruction !== 32'h2000_0002) begin fails++; $display("FAIL unstall_instr got %h exp 20000002", if_id_instruction); end
        tests++; if (fetch_count !== 32'd3) begin fails++; $display("FAIL unstall_count got %0d exp 3", fetch_count); end
        tests++; if (pc !== 32'd12) begin fails++; $display("FAIL unstall_pc got %0d exp 12", pc); end
    endtask

    task automatic test_branch_vs_stall();
        branch_taken = 1'b1; branch_target = 32'h28; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        tests++; if (pc !== 32'h28) begin fails++; $display("FAIL br_pc got %h exp 28", pc); end
        tests++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'd0 || if_id_pc_plus4 !== 32'd0)
            begin fails++; $display("FAIL br_bubble got %h/%h/%b exp 0/0/0", if_id_instruction, if_id_pc_plus4, if_id_valid); end
        tests++; if (fetch_count !== 32'd3) begin fails++; $display("FAIL br_count got %0d exp 3", fetch_count); end
        step();
        tests++; if (if_id_instruction !== 32'h2000_000A || if_id_valid !== 1'b1)
            begin fails++; $display("FAIL br_target got %h/%b exp 2000000a/1", if_id_instruction, if_id_valid); end
        tests++; if (if_id_pc_plus4 !== 32'h2C || pc !== 32'h2C) begin fails++; $display("FAIL br_next got %h/%h exp 2c/2c", if_id_pc_plus4, pc); end
        tests++; if (fetch_count !== 32'd4) begin fails++; $display("FAIL br_count2 got %0d exp 4", fetch_count); end
    endtask

    task automatic halt_at(input logic [31:0] tgt);
        logic [31:0] cnt;
        cnt = fetch_count;
        branch_taken = 1'b1; branch_target = tgt;
        step();
        branch_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests++; if (out_of_range !== 1'b1) begin fails++; $display("FAIL oor_flag tgt %h got %b exp 1", tgt, out_of_range); end
            tests++; if (pc !== tgt || if_id_valid !== 1'b0) begin fails++; $display("FAIL oor_hold got pc %h valid %b exp %h/0", pc, if_id_valid, tgt); end
            tests++; if (fetch_count !== cnt) begin fails++; $display("FAIL oor_count got %0d exp %0d", fetch_count, cnt); end
            tests++; if (if_id_instruction !== 32'd0) begin fails++; $display("FAIL oor_instr got %h exp 0", if_id_instruction); end
            step();
        end
        branch_taken = 1'b1; branch_target = 32'd0;
        step();
        branch_taken = 1'b0;
        tests++; if (pc !== 32'd0 || out_of_range !== 1'b0) begin fails++; $display("FAIL oor_resume_pc got %h/%b exp 0/0", pc, out_of_range); end
        step();
        tests++; if (if_id_instruction !== 32'h2000_0000 || if_id_valid !== 1'b1) begin fails++; $display("FAIL oor_resume_fetch got %h/%b exp 20000000/1", if_id_instruction, if_id_valid); end
        tests++; if (fetch_count !== cnt + 32'd1) begin fails++; $display("FAIL oor_resume_count got %0d exp %0d", fetch_count, cnt + 32'd1); end
    endtask

    task automatic test_out_of_range();
        halt_at(32'h100);
        halt_at(32'h6);
    endtask

    task automatic test_reset_halted();
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        step();
        tests++; if (out_of_range !== 1'b1) begin fails++; $display("FAIL rh_setup got %b exp 1", out_of_range); end
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        step();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        tests++; if (pc !== 32'd0 || out_of_range !== 1'b0) begin fails++; $display("FAIL rh_pc got %h/%b exp 0/0", pc, out_of_range); end
        tests++; if (fetch_count !== 32'd0 || if_id_valid !== 1'b0) begin fails++; $display("FAIL rh_state got %0d/%b exp 0/0", fetch_count, if_id_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_vs_stall();
        test_out_of_range();
        test_reset_halted();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
